// File: rtl/mem_stage.sv
// Memory-access pipeline stage: extracts/extends load data, forwards write-back value to WB and ID.
// Latency: one cycle EXE->MS register; final_result is combinational from the register and SRAM data.
// Backpressure: ms_allowin drops while a valid instruction waits on WB; SRAM data is held across the stall.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [75:0] es_to_ms_bus,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [37:0] ms_fwd_bus
);

    typedef struct packed {
        logic [4:0]  load_op;
        logic        mem_to_reg;
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ws_bus_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } fwd_bus_t;

    logic        ms_valid;
    logic        ms_ready_go;
    logic        ms_latch;
    logic        ms_first;
    logic        rdata_held;
    logic [31:0] rdata_buf;
    es_bus_t     ms_bus;
    logic [31:0] mem_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ws_bus_t     ws_bus;
    fwd_bus_t    fwd_bus;

    // Memory access never needs extra cycles here; the SRAM answers in time.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_latch       = es_to_ms_valid && ms_allowin;

    // Occupancy flag: refilled from EXE whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register; contents are don't-care while ms_valid is low, so no reset.
    always_ff @(posedge clk) begin
        if (ms_latch) begin
            ms_bus <= es_to_ms_bus;
        end
    end

    // First-cycle marker: the SRAM output belongs to this instruction only right after latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_first <= 1'b0;
        end else begin
            ms_first <= ms_latch;
        end
    end

    // Hold flag: once WB stalls on the first cycle, later SRAM outputs no longer belong to us.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_held <= 1'b0;
        end else if (ms_latch || (ms_valid && ws_allowin)) begin
            rdata_held <= 1'b0;
        end else if (ms_first && ms_valid && !ws_allowin) begin
            rdata_held <= 1'b1;
        end
    end

    // Capture the SRAM word at the edge where the hold begins.
    always_ff @(posedge clk) begin
        if (ms_first && ms_valid && !ws_allowin) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign mem_word = rdata_held ? rdata_buf : data_sram_rdata;

    // Byte/halfword lane selection by the low address bits; addr[0] is ignored for halfwords.
    always_comb begin
        byte_sel = mem_word[7:0];
        case (ms_bus.alu_result[1:0])
            2'b00:   byte_sel = mem_word[7:0];
            2'b01:   byte_sel = mem_word[15:8];
            2'b10:   byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = ms_bus.alu_result[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Extension per one-hot load_op; ld.w (or no load) passes the word through.
    always_comb begin
        load_data = mem_word;
        if (ms_bus.load_op[0]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (ms_bus.load_op[1]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (ms_bus.load_op[3]) begin
            load_data = {24'h0, byte_sel};
        end else if (ms_bus.load_op[4]) begin
            load_data = {16'h0, half_sel};
        end
    end

    assign final_result = ms_bus.mem_to_reg ? load_data : ms_bus.alu_result;

    // Output buses to WB and the ID bypass.
    always_comb begin
        ws_bus.reg_we       = ms_bus.reg_we;
        ws_bus.dest         = ms_bus.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus.pc;
        fwd_bus.we          = ms_valid && ms_bus.reg_we && (ms_bus.dest != 5'd0);
        fwd_bus.dest        = ms_bus.dest;
        fwd_bus.data        = final_result;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_fwd_bus   = fwd_bus;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage LoongArch-subset CPU, located between `exe_stage` and `wb_stage`. It takes one instruction per cycle from EXE over the valid/allowin handshake. For load instructions it extracts and extends the data that the synchronous data SRAM returns one cycle after EXE issued the address. It then forwards the final write-back value to WB and drives a bypass bus to ID. It also keeps the SRAM read data when WB stalls, because the SRAM output is only valid in the first cycle of occupancy.

## Interface
- No parameters. Widths come from `mycpu.h`: `ES_TO_MS_BUS_WD`=76, `MS_TO_WS_BUS_WD`=70.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `ws_allowin`  in  1  WB can accept an instruction this cycle.
- `ms_allowin`  out  1  MS can accept an instruction this cycle.
- `es_to_ms_valid`  in  1  EXE presents a valid instruction.
- `es_to_ms_bus`  in  76  {load_op[75:71], mem_to_reg[70], reg_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- `data_sram_rdata`  in  32  SRAM read word for the address EXE drove in the previous cycle.
- `ms_to_ws_valid`  out  1  MS presents a valid instruction to WB.
- `ms_to_ws_bus`  out  70  {reg_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- `ms_fwd_bus`  out  38  {fwd_we[37], fwd_dest[36:32], fwd_data[31:0]} bypass to ID.

## Operation
- Pipeline register and handshake:
  - `ms_ready_go`=1.
  - `ms_allowin` = !ms_valid || ws_allowin.
  - `ms_to_ws_valid` = ms_valid.
  - When ms_allowin=1: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: bus register <= es_to_ms_bus.
- `load_op` is one-hot: bit0 ld.b, bit1 ld.h, bit2 ld.w, bit3 ld.bu, bit4 ld.hu. All zero means not a load.
- Byte select uses addr[1:0] = alu_result[1:0]: 00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24].
- Halfword select uses addr[1]: 0→[15:0], 1→[31:16]. addr[0] is ignored; alignment faults are not detected here.
- ld.b and ld.h sign-extend. ld.bu and ld.hu zero-extend. ld.w passes the word unchanged.
- final_result = mem_to_reg ? load_data : alu_result.
- Read-data hold:
  - `ms_first` is set when an instruction is latched and cleared on the next edge.
  - `rdata_held` is set when ms_first && ms_valid && !ws_allowin. At that edge, `rdata_buf` <= data_sram_rdata.
  - `rdata_held` is cleared when the instruction leaves (ms_valid && ws_allowin) or when a new instruction is latched.
  - Effective word = rdata_held ? rdata_buf : data_sram_rdata.
- Forward bus:
  - fwd_we = ms_valid && reg_we && dest!=0.
  - fwd_dest = dest; fwd_data = final_result.
  - Load results are available here, so ID needs no load-use stall on an MS hit.

## Timing
- Reset values: ms_valid=0, ms_first=0, rdata_held=0, so ms_to_ws_valid=0, ms_allowin=1 and fwd_we=0.
- The bus register and rdata_buf are not reset. `ms_to_ws_bus` and fwd_dest/fwd_data are don't-care while the corresponding valid/we is 0.
- Latency: one cycle EXE→MS. final_result is combinational from the register and the SRAM data in the same cycle.
- WB stalls for N cycles: final_result stays constant for all N+1 cycles, even though data_sram_rdata changes after cycle 1.
- Simultaneous leave and enter (ms_valid && ws_allowin && es_to_ms_valid): the new instruction is latched, ms_first=1, rdata_held=0, and there are no bubbles.
- Leave with no new input: ms_valid drops to 0 on the next edge.
- Reset mid-stall: the held instruction is discarded and ms_valid=0 on the next edge, whatever ws_allowin is.

## Test plan
- Back-to-back ALU ops, ws_allowin=1, alu_result=0x12345678, reg_we=1, dest=5 → one cycle later ms_to_ws_bus.final_result=0x12345678 and fwd={1,5,0x12345678}. Throughput is 1 per cycle.
- Load sweep with rdata=0x80FF7F01: ld.b @+0→0x00000001, @+1→0x0000007F, @+2→0xFFFFFFFF, @+3→0xFFFFFF80; ld.bu @+3→0x00000080; ld.h @+0→0x00007F01, @+2→0xFFFF80FF; ld.hu @+2→0x000080FF; ld.w→0x80FF7F01.
- ld.w with rdata=0xDEADBEEF in cycle 1, then rdata=0x0 after it, ws_allowin=0 for 3 cycles → final_result=0xDEADBEEF in all 4 cycles, ms_allowin=0 during the stall, and the instruction leaves exactly once.
- dest=0 with reg_we=1 → fwd_we=0. Load with ws_allowin toggling 0/1 every cycle → no instruction is lost or duplicated (compare against a pc scoreboard).
- Assert reset while holding a stalled load → next cycle ms_to_ws_valid=0, ms_allowin=1, fwd_we=0. The first post-reset load uses live rdata, not the stale rdata_buf.
